// File: rtl/glip_stream_source.sv
// Test-pattern stream source with valid/ready flow control and per-window throughput measurement.
// Optional feature: define GLIP_STREAM_SOURCE_STALL_EN to add the stall_cycles output.
module glip_stream_source #(
    parameter logic [31:0] FREQ = 32'd10000000,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode,
    input  logic [15:0] burst_len,
    output logic [15:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic [31:0] words_per_sec,
    output logic        rate_update
`ifdef GLIP_STREAM_SOURCE_STALL_EN
    ,
    output logic [31:0] stall_cycles
`endif
);

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 32;

    localparam logic [1:0] MODE_INC   = 2'd0;
    localparam logic [1:0] MODE_LFSR  = 2'd1;
    localparam logic [1:0] MODE_WALK  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_n;
    logic [DW-1:0] data_n;
    logic          valid_n, busy_n, done_n;
    logic [1:0]    mode_q, mode_n;
    logic [DW-1:0] len_q, len_n;
    logic [DW-1:0] sent_q, sent_n;
    logic          stop_q, stop_n;
    logic          transfer;

    logic [CW-1:0] cyc_cnt;
    logic [CW-1:0] window_cnt;
    logic [CW-1:0] window_inc;

    assign transfer = out_valid & out_ready;

    function automatic logic [DW-1:0] first_word(input logic [1:0] m);
        case (m)
            MODE_INC:  first_word = 16'h0000;
            MODE_LFSR: first_word = SEED;
            MODE_WALK: first_word = 16'h0001;
            default:   first_word = 16'hA5A5;
        endcase
    endfunction

    function automatic logic [DW-1:0] advance(input logic [1:0] m, input logic [DW-1:0] d);
        case (m)
            MODE_INC:  advance = d + 16'd1;
            MODE_LFSR: advance = {d[14:0], d[15] ^ d[13] ^ d[12] ^ d[10]};
            MODE_WALK: advance = {d[14:0], d[15]};
            default:   advance = d;
        endcase
    endfunction

    // FSM and burst state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mode_q    <= '0;
            len_q     <= '0;
            sent_q    <= '0;
            stop_q    <= 1'b0;
        end else begin
            state     <= state_n;
            out_data  <= data_n;
            out_valid <= valid_n;
            busy      <= busy_n;
            done      <= done_n;
            mode_q    <= mode_n;
            len_q     <= len_n;
            sent_q    <= sent_n;
            stop_q    <= stop_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n = state;
        data_n  = out_data;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        mode_n  = mode_q;
        len_n   = len_q;
        sent_n  = sent_q;
        stop_n  = stop_q;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_n  = mode;
                    len_n   = burst_len;
                    data_n  = first_word(mode);
                    sent_n  = '0;
                    stop_n  = 1'b0;
                    state_n = RUN;
                    valid_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            RUN: begin
                valid_n = 1'b1;
                busy_n  = 1'b1;
                stop_n  = stop_q | stop;
                if (transfer) begin
                    data_n = advance(mode_q, out_data);
                    sent_n = sent_q + 16'd1;
                    stop_n = 1'b0;
                    // a stop seen any time since the previous transfer ends the burst here
                    if ((len_q != '0 && sent_q == len_q - 16'd1) || stop || stop_q) begin
                        state_n = DONE;
                        valid_n = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign window_inc = (transfer && window_cnt != '1) ? window_cnt + 32'd1 : window_cnt;

    // Free-running measurement window; the final cycle's transfer is included in the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt       <= '0;
            window_cnt    <= '0;
            words_per_sec <= '0;
            rate_update   <= 1'b0;
        end else begin
            rate_update <= 1'b0;
            if (cyc_cnt == FREQ - 32'd1) begin
                cyc_cnt       <= '0;
                window_cnt    <= '0;
                words_per_sec <= window_inc;
                rate_update   <= 1'b1;
            end else begin
                cyc_cnt    <= cyc_cnt + 32'd1;
                window_cnt <= window_inc;
            end
        end
    end

`ifdef GLIP_STREAM_SOURCE_STALL_EN
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] stall_inc;

    assign stall_inc = (out_valid && !out_ready && stall_cnt != '1) ? stall_cnt + 32'd1 : stall_cnt;

    // Stalled-cycle count, latched alongside words_per_sec
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt    <= '0;
            stall_cycles <= '0;
        end else if (cyc_cnt == FREQ - 32'd1) begin
            stall_cnt    <= '0;
            stall_cycles <= stall_inc;
        end else begin
            stall_cnt <= stall_inc;
        end
    end
`endif

endmodule

// File: tb/tb_glip_stream_source.sv
// Scoreboard bench for glip_stream_source: directed bursts, flow control, stop, rate window, reset.
module tb_glip_stream_source;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic [1:0]  mode;
    logic [15:0] burst_len;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic [31:0] words_per_sec;
    logic        rate_update;
`ifdef GLIP_STREAM_SOURCE_STALL_EN
    logic [31:0] stall_cycles;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [15:0] exp_q[$];

    glip_stream_source #(.FREQ(32'd20), .SEED(16'hACE1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .stop          (stop),
        .mode          (mode),
        .burst_len     (burst_len),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .done          (done),
        .words_per_sec (words_per_sec),
        .rate_update   (rate_update)
`ifdef GLIP_STREAM_SOURCE_STALL_EN
        ,
        .stall_cycles  (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks stall stability
    logic        hold_pend = 1'b0;
    logic [15:0] hold_data = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("valid_held", 32'(out_valid), 32'd1);
                check("data_held", 32'(out_data), 32'(hold_data));
            end
            hold_pend = out_valid && !out_ready;
            hold_data = out_data;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_word: got %h, required none", out_data);
                end else begin
                    check("data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start a burst; mode/burst_len are then scrambled to prove they were latched
    task automatic pulse_start(input logic [1:0] m, input logic [15:0] len);
        mode      = m;
        burst_len = len;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        mode      = m ^ 2'b01;
        burst_len = len + 16'd2;
        check("busy_run", 32'(busy), 32'd1);
    endtask

    task automatic wait_done(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            tick();
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_valid_off"}, 32'(out_valid), 32'd0);
        tick();
        check({name, "_done_once"}, 32'(done), 32'd0);
        check({name, "_idle"}, 32'(busy), 32'd0);
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, required finished");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int nupd;
        int last;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = '0; burst_len = '0; out_ready = 1'b0;
        #23;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_wps", words_per_sec, 32'd0);
        check("rst_upd", 32'(rate_update), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: increment, len 4, back-to-back
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(i));
        out_ready = 1'b1;
        pulse_start(2'd0, 16'd4);
        repeat (3) tick();
        check("t1_no_early_done", 32'(done), 32'd0);
        tick();
        check("t1_done_on_time", 32'(done), 32'd1);
        wait_done("t1", 2);

        // 2: LFSR then walking-one with wrap
        exp_q.push_back(16'hACE1);
        exp_q.push_back(16'h59C3);
        exp_q.push_back(16'hB387);
        pulse_start(2'd1, 16'd3);
        wait_done("t2a", 10);
        for (int i = 0; i < 16; i++) exp_q.push_back(16'(16'h0001 << i));
        exp_q.push_back(16'h0001);
        pulse_start(2'd2, 16'd17);
        wait_done("t2b", 30);

        // 3: alternating ready, len 5
        for (int i = 0; i < 5; i++) exp_q.push_back(16'(i));
        out_ready = 1'b0;
        pulse_start(2'd0, 16'd5);
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            out_ready = (i % 2 == 0);
            tick();
        end
        wait_done("t3", 2);

        // 4: continuous, stop pulsed while stalled -> exactly one more word
        for (int i = 0; i <= 100; i++) exp_q.push_back(16'(i));
        out_ready = 1'b1;
        pulse_start(2'd0, 16'd0);
        repeat (100) tick();
        out_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tick();
        tick();
        check("t4_still_valid", 32'(out_valid), 32'd1);
        check("t4_not_done", 32'(done), 32'd0);
        out_ready = 1'b1;
        tick();
        wait_done("t4", 1);

        // 5a: full-rate window
        for (int i = 0; i <= 70; i++) exp_q.push_back(16'(i));
        pulse_start(2'd0, 16'd0);
        nupd = 0;
        last = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (rate_update) begin
                nupd++;
                if (nupd >= 2) begin
                    check("t5a_wps", words_per_sec, 32'd20);
                    check("t5a_period", 32'(i - last), 32'd20);
                end
                last = i;
            end
        end
        check("t5a_updates", 32'(nupd >= 3), 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("t5a", 2);

        // 5b: half-rate window
        for (int i = 0; i <= 40; i++) exp_q.push_back(16'(i));
        pulse_start(2'd0, 16'd0);
        nupd = 0;
        for (int i = 0; i < 80; i++) begin
            out_ready = (i % 2 == 0);
            tick();
            if (rate_update) begin
                nupd++;
                if (nupd >= 2) begin
                    check("t5b_wps", words_per_sec, 32'd10);
`ifdef GLIP_STREAM_SOURCE_STALL_EN
                    check("t5b_stall", stall_cycles, 32'd10);
`endif
                end
            end
        end
        check("t5b_updates", 32'(nupd >= 3), 32'd1);
        out_ready = 1'b0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        out_ready = 1'b1;
        tick();
        wait_done("t5b", 2);

        // 6: asynchronous reset mid-burst, then restart from seed
        exp_q.push_back(16'hACE1);
        exp_q.push_back(16'h59C3);
        pulse_start(2'd1, 16'd10);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid_async", 32'(out_valid), 32'd0);
        check("t6_busy_async", 32'(busy), 32'd0);
        check("t6_data_async", 32'(out_data), 32'd0);
        check("t6_wps_async", words_per_sec, 32'd0);
        check("t6_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        exp_q.push_back(16'hACE1);
        exp_q.push_back(16'h59C3);
        exp_q.push_back(16'hB387);
        pulse_start(2'd1, 16'd3);
        wait_done("t6", 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
